// File: rtl/cbx_param_ccff.sv
// X-channel connection block: straight-through tracks plus NUM_IPIN routing muxes whose
// selects come from a serial config chain that is copied into a shadow register on commit.
module cbx_param_ccff #(
    parameter int CHAN_W   = 20,
    parameter int NUM_IPIN = 6,
    parameter int MUX_SIZE = 8,
    parameter int STRIDE   = 6,
    parameter int CHK_LEN  = 18
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                ccff_commit,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic                ccff_tail,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int SEL_W    = $clog2(MUX_SIZE);
    localparam int CFG_BITS = NUM_IPIN * SEL_W;
    localparam int CNT_W    = $clog2(CHK_LEN + 2);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHK_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_CHK = CNT_W'(CHK_LEN);

    typedef enum logic [1:0] {
        UNCFG   = 2'd0,
        LOADING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CFG_BITS-1:0] sr;
    logic [CFG_BITS-1:0] shadow;
    logic [CNT_W-1:0]    cnt;
    logic                has_cfg;
    logic                shift_en;
    logic                commit_ok;

    assign chanx_right_out = chanx_left_in;
    assign chanx_left_out  = chanx_right_in;
    assign ccff_tail       = sr[CFG_BITS-1];

    // A commit in the same cycle as an enable suppresses the shift.
    assign shift_en  = ccff_en && !ccff_commit;
    assign commit_ok = ccff_commit && ((CHK_LEN == 0) || (cnt == CNT_CHK));

    // Configuration datapath: shift chain, shadow copy, shift counter, status flags.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sr      <= '0;
            shadow  <= '0;
            cnt     <= '0;
            has_cfg <= 1'b0;
            cfg_err <= 1'b0;
        end else if (ccff_commit) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values,
            // which is what lets shadow capture sr in the same edge without ordering hazards.
            cnt <= '0;
            if (commit_ok) begin
                shadow  <= sr;
                has_cfg <= 1'b1;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end else if (shift_en) begin
            sr <= {sr[CFG_BITS-2:0], ccff_head};
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state <= UNCFG;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_next = state;
        unique case (state)
            UNCFG: begin
                if (commit_ok) begin
                    state_next = ACTIVE;
                end else if (shift_en) begin
                    state_next = LOADING;
                end
            end
            LOADING: begin
                if (ccff_commit) begin
                    state_next = (commit_ok || has_cfg) ? ACTIVE : UNCFG;
                end
            end
            ACTIVE: begin
                if (shift_en) begin
                    state_next = LOADING;
                end
            end
            default: state_next = UNCFG;
        endcase
    end

    // While loading over an earlier commit, the old shadow keeps routing.
    always_comb begin
        cfg_valid = 1'b0;
        unique case (state)
            ACTIVE:  cfg_valid = 1'b1;
            LOADING: cfg_valid = has_cfg;
            default: cfg_valid = 1'b0;
        endcase
    end

    for (genvar k = 0; k < NUM_IPIN; k++) begin : g_ipin
        logic [SEL_W-1:0]    sel;
        logic [MUX_SIZE-1:0] mux_in;

        assign sel = shadow[k*SEL_W +: SEL_W];

        // Input pair j>>1 taps track (k + pair*STRIDE) mod CHAN_W; even j left, odd j right.
        for (genvar j = 0; j < MUX_SIZE; j++) begin : g_in
            localparam int TRK = (k + (j / 2) * STRIDE) % CHAN_W;
            if (j % 2 == 0) begin : g_left
                assign mux_in[j] = chanx_left_in[TRK];
            end else begin : g_right
                assign mux_in[j] = chanx_right_in[TRK];
            end
        end

        assign ipin_out[k] = (cfg_valid && (int'(sel) < MUX_SIZE)) ? mux_in[sel] : 1'b0;
    end

endmodule

// File: tb/tb_cbx_param_ccff.sv
// Directed self-checking bench for cbx_param_ccff with default parameters (18 config bits).
module tb_cbx_param_ccff;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        ccff_head;
    logic        ccff_en;
    logic        ccff_commit;
    logic [19:0] chanx_left_in;
    logic [19:0] chanx_right_in;
    logic [19:0] chanx_left_out;
    logic [19:0] chanx_right_out;
    logic [5:0]  ipin_out;
    logic        ccff_tail;
    logic        cfg_valid;
    logic        cfg_err;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [17:0] SEL3_ALL = 18'b011_011_011_011_011_011;
    localparam logic [17:0] SEL0_ALL = 18'b000_000_000_000_000_000;
    localparam logic [17:0] W1       = 18'h2D3A5;

    cbx_param_ccff dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .ccff_head       (ccff_head),
        .ccff_en         (ccff_en),
        .ccff_commit     (ccff_commit),
        .chanx_left_in   (chanx_left_in),
        .chanx_right_in  (chanx_right_in),
        .chanx_left_out  (chanx_left_out),
        .chanx_right_out (chanx_right_out),
        .ipin_out        (ipin_out),
        .ccff_tail       (ccff_tail),
        .cfg_valid       (cfg_valid),
        .cfg_err         (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic shift_bit(input logic b);
        @(negedge prog_clk);
        ccff_en   = 1'b1;
        ccff_head = b;
        @(posedge prog_clk);
        #1;
        ccff_en   = 1'b0;
    endtask

    // First bit shifted ends up in the MSB of the register.
    task automatic shift_word(input logic [17:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            shift_bit(w[17-i]);
        end
    endtask

    task automatic commit_pulse();
        @(negedge prog_clk);
        ccff_commit = 1'b1;
        @(posedge prog_clk);
        #1;
        ccff_commit = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge prog_clk);
        pReset = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b1;
    endtask

    initial begin
        pReset         = 1'b0;
        ccff_head      = 1'b0;
        ccff_en        = 1'b0;
        ccff_commit    = 1'b0;
        chanx_left_in  = 20'h5A5A5;
        chanx_right_in = 20'h0;

        // Reset and idle
        #12;
        check("passthru_in_reset", chanx_right_out, 20'h5A5A5);
        @(negedge prog_clk);
        pReset = 1'b1;
        repeat (2) @(posedge prog_clk);
        #1;
        check("rst_ipin", ipin_out, 6'h00);
        check("rst_valid", cfg_valid, 1'b0);
        check("rst_tail", ccff_tail, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        chanx_right_in = 20'hA5A5A;
        #1;
        check("passthru_left", chanx_left_out, 20'hA5A5A);

        // Load select 3 everywhere; nothing routes before commit
        chanx_left_in  = 20'h0;
        chanx_right_in = 20'hFFFFF;
        shift_word(SEL3_ALL, 18);
        check("loading_valid", cfg_valid, 1'b0);
        check("loading_ipin", ipin_out, 6'h00);
        commit_pulse();
        check("c1_valid", cfg_valid, 1'b1);
        check("c1_err", cfg_err, 1'b0);
        check("c1_all", ipin_out, 6'h3F);
        chanx_right_in = 20'h0;
        chanx_left_in  = 20'hFFFFF;
        #1;
        check("c1_left_ignored", ipin_out, 6'h00);
        chanx_left_in  = 20'h0;
        chanx_right_in = 20'h00040;
        #1;
        check("c1_ipin0_r6", ipin_out, 6'h01);
        chanx_right_in = 20'h00800;
        #1;
        check("c1_ipin5_r11", ipin_out, 6'h20);

        // Shift all-zero selects without commit: old shadow keeps routing
        chanx_right_in = 20'h00040;
        shift_word(SEL0_ALL, 18);
        check("shadow_hold_ipin", ipin_out, 6'h01);
        check("shadow_hold_valid", cfg_valid, 1'b1);
        commit_pulse();
        check("c2_err", cfg_err, 1'b0);
        check("c2_right_ignored", ipin_out, 6'h00);
        chanx_right_in = 20'h0;
        chanx_left_in  = 20'h00001;
        #1;
        check("c2_ipin0_l0", ipin_out, 6'h01);
        chanx_left_in  = 20'h0002A;
        #1;
        check("c2_ipin_l_odd", ipin_out, 6'h2A);

        // Enable and commit together: commit accepted, no shift
        chanx_left_in  = 20'h0;
        chanx_right_in = 20'h00040;
        shift_word(SEL3_ALL, 18);
        @(negedge prog_clk);
        ccff_en     = 1'b1;
        ccff_commit = 1'b1;
        ccff_head   = 1'b1;
        @(posedge prog_clk);
        #1;
        ccff_en     = 1'b0;
        ccff_commit = 1'b0;
        check("both_err", cfg_err, 1'b0);
        check("both_ipin", ipin_out, 6'h01);
        check("both_tail", ccff_tail, 1'b0);
        // Counter must have cleared, so an immediate commit is rejected
        commit_pulse();
        check("cnt0_err", cfg_err, 1'b1);
        check("cnt0_valid", cfg_valid, 1'b1);
        check("cnt0_ipin", ipin_out, 6'h01);

        // Head-to-tail latency: 18 shifts
        shift_word(W1, 18);
        check("tail_w1_msb", ccff_tail, W1[17]);
        for (int i = 0; i < 17; i++) begin
            shift_bit(1'b0);
            check($sformatf("tail_d%0d", i), ccff_tail, W1[16-i]);
        end
        repeat (3) @(posedge prog_clk);
        #1;
        check("tail_idle_hold", ccff_tail, W1[0]);

        // Short load with no prior config is rejected
        apply_reset();
        chanx_left_in  = 20'hFFFFF;
        chanx_right_in = 20'hFFFFF;
        shift_word(SEL3_ALL, 17);
        commit_pulse();
        check("short_err", cfg_err, 1'b1);
        check("short_valid", cfg_valid, 1'b0);
        check("short_ipin", ipin_out, 6'h00);
        shift_word(SEL3_ALL, 18);
        commit_pulse();
        check("retry_err", cfg_err, 1'b0);
        check("retry_valid", cfg_valid, 1'b1);
        chanx_left_in  = 20'h0;
        chanx_right_in = 20'h00040;
        #1;
        check("retry_ipin", ipin_out, 6'h01);

        // Asynchronous reset in the middle of a reload
        chanx_right_in = 20'hFFFFF;
        shift_word(SEL0_ALL, 9);
        check("pre_rst_ipin", ipin_out, 6'h3F);
        @(negedge prog_clk);
        ccff_en   = 1'b1;
        ccff_head = 1'b1;
        #2;
        pReset = 1'b0;
        #1;
        check("async_ipin", ipin_out, 6'h00);
        check("async_valid", cfg_valid, 1'b0);
        check("async_tail", ccff_tail, 1'b0);
        check("async_passthru", chanx_left_out, 20'hFFFFF);
        ccff_en = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b1;
        check("post_rst_ipin", ipin_out, 6'h00);
        shift_word(SEL3_ALL, 18);
        commit_pulse();
        check("restore_valid", cfg_valid, 1'b1);
        chanx_right_in = 20'h00800;
        #1;
        check("restore_ipin5", ipin_out, 6'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cbx_param_ccff.md
# cbx_param_ccff

Parametrised X-channel connection block with a shadow-committed configuration chain. It passes CHAN_W tracks straight through in each direction and drives NUM_IPIN grid input pins, each from a MUX_SIZE-input routing mux. Mux selects come from a serial ccff shift chain that is copied into a shadow register on an explicit commit, so the routing never sees partially shifted bits. It sits between the logic tiles on the horizontal channel and is daisy-chained via ccff_head/ccff_tail with neighbouring blocks.

## Interface
- CHAN_W, 20: tracks per direction.
- NUM_IPIN, 6: grid input pins driven.
- MUX_SIZE, 8: inputs per ipin mux; even, 2..CHAN_W*2.
- STRIDE, 6: track step between mux input pairs.
- CHK_LEN, 18: shifts expected per commit; 0 disables the check.
- SEL_W (derived) = clog2(MUX_SIZE). CFG_BITS (derived) = NUM_IPIN*SEL_W.

- prog_clk  in  1  configuration clock; all state on rising edge.
- pReset  in  1  asynchronous, active-low reset.
- ccff_head  in  1  serial config data in.
- ccff_en  in  1  shift enable.
- ccff_commit  in  1  one-cycle commit strobe.
- chanx_left_in, chanx_right_in  in  CHAN_W  channel tracks.
- chanx_left_out, chanx_right_out  out  CHAN_W  pass-through tracks.
- ipin_out  out  NUM_IPIN  grid input pins.
- ccff_tail  out  1  serial config data out = sr[CFG_BITS-1].
- cfg_valid  out  1  shadow holds a committed configuration.
- cfg_err  out  1  sticky: last commit rejected.

## Operation
- Pass-through is combinational: chanx_right_out = chanx_left_in; chanx_left_out = chanx_right_in.
- Mux input mapping for ipin k, input j:
  - Track t = (k + (j>>1)*STRIDE) mod CHAN_W.
  - j even selects chanx_left_in[t]; j odd selects chanx_right_in[t].
- Select for ipin k = shadow[k*SEL_W +: SEL_W].
- ipin_out[k] = 0 when cfg_valid = 0 or when the select is >= MUX_SIZE.
- Shift, when ccff_en = 1 and ccff_commit = 0: sr <= {sr[CFG_BITS-2:0], ccff_head}. The first bit shifted lands in the MSB of ipin NUM_IPIN-1.
- Shift counter cnt counts shifts since the last commit and saturates at CHK_LEN+1.
- Commit (ccff_commit = 1):
  - Accepted if CHK_LEN = 0 or cnt == CHK_LEN. Then shadow <= sr, cfg_valid <= 1, cfg_err <= 0.
  - Otherwise rejected: shadow and cfg_valid are unchanged, cfg_err <= 1.
  - cnt <= 0 in both cases.
- Simultaneous ccff_en and ccff_commit: commit wins and no shift occurs that cycle.
- State machine:
  - UNCFG: state after reset.
  - UNCFG -> LOADING on first shift. LOADING -> ACTIVE on an accepted commit. LOADING -> UNCFG on a rejected commit if cfg_valid = 0.
  - ACTIVE -> LOADING on a shift; the old shadow keeps routing. LOADING -> ACTIVE on any commit when cfg_valid = 1; cfg_err reports the result.
  - cfg_valid = 1 exactly in ACTIVE, and in LOADING after a prior accepted commit.
- Reset mid-shift or mid-commit clears everything. Routing goes to 0 immediately (asynchronous).

## Timing
- Reset values: sr = 0, shadow = 0, cnt = 0, cfg_valid = 0, cfg_err = 0, ccff_tail = 0, ipin_out = 0, state UNCFG. Pass-through outputs follow their inputs during reset.
- ccff_head to ccff_tail latency: CFG_BITS enabled cycles. ccff_tail changes only on shift edges.
- A commit sampled at edge N updates shadow, cfg_valid and cfg_err at edge N. ipin_out reflects the new selects combinationally after edge N.
- Track to ipin_out and track to pass-through paths are purely combinational with no register stage.
- Chaining several blocks: set CHK_LEN to the total chain length, or to 0.

## Test plan
- Reset then idle -> ipin_out = 0, cfg_valid = 0, ccff_tail = 0; chanx_left_in = 0x5A5A5 gives chanx_right_out = 0x5A5A5.
- Shift 18 bits so every select = 3, then commit -> cfg_valid = 1, cfg_err = 0.
  - ipin0 follows chanx_right_in[6] and ipin5 follows chanx_right_in[11]; toggle each track and check.
- Shift 17 bits, then commit -> cfg_err = 1, cfg_valid = 0, ipin_out = 0.
  - Follow with 18 shifts and a commit -> cfg_err = 0, cfg_valid = 1.
- With select 3 active, shift a new pattern of all 0 without committing -> ipin0 still tracks chanx_right_in[6].
  - After the commit, ipin0 tracks chanx_left_in[0].
- Drive ccff_en = ccff_commit = 1 together -> sr unchanged, cnt = 0.
  - Check ccff_tail reproduces ccff_head delayed by 18 shifts.
- Assert pReset low mid-shift (bit 9) while ACTIVE -> ipin_out = 0 and cfg_valid = 0 immediately.
  - After release, an 18-shift commit restores routing.
